// File: rtl/addsub15_slice_seq.sv
// Sequential 15-bit adder/subtractor: one 3-bit carry-lookahead slice per clock, LSB first.
// Define ADDSUB15_OVF_EN to build the signed-overflow output; otherwise ovf is tied to 0.
module addsub15_slice_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] a,
  input  logic [14:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state_q, state_d;
  logic [14:0] opA_q, opA_d;
  logic [14:0] opB_q, opB_d;
  logic [14:0] sum_q, sum_d;
  logic        carry_q, carry_d;
  logic [2:0]  sliceIdx_q, sliceIdx_d;
  logic        cout_q, cout_d;

  logic [2:0]  sliceG, sliceP, sliceSum;
  logic        c1, c2, c3;

  // Operands shift right by one slice per cycle, so the active slice is always bits [2:0].
  always_comb begin
    sliceG   = opA_q[2:0] & opB_q[2:0];
    sliceP   = opA_q[2:0] ^ opB_q[2:0];
    c1       = sliceG[0] | (sliceP[0] & carry_q);
    c2       = sliceG[1] | (sliceP[1] & sliceG[0]) | (sliceP[1] & sliceP[0] & carry_q);
    c3       = sliceG[2] | (sliceP[2] & sliceG[1]) | (sliceP[2] & sliceP[1] & sliceG[0])
             | (sliceP[2] & sliceP[1] & sliceP[0] & carry_q);
    sliceSum = sliceP ^ {c2, c1, carry_q};
  end

`ifdef ADDSUB15_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      sliceIdx_q <= '0;
      cout_q     <= 1'b0;
`ifdef ADDSUB15_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      sliceIdx_q <= sliceIdx_d;
      cout_q     <= cout_d;
`ifdef ADDSUB15_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  // Result bits enter at the top of sum_q; after five slices slice 0 has reached bit 0.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    sliceIdx_d = sliceIdx_q;
    cout_d     = cout_q;
`ifdef ADDSUB15_OVF_EN
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d      = a;
          opB_d      = b ^ {15{sub}};
          carry_d    = sub;
          sliceIdx_d = 3'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        opA_d   = {3'b000, opA_q[14:3]};
        opB_d   = {3'b000, opB_q[14:3]};
        sum_d   = {sliceSum, sum_q[14:3]};
        carry_d = c3;
        if (sliceIdx_q == 3'd4) begin
          cout_d  = c3;
`ifdef ADDSUB15_OVF_EN
          // On the last slice c2 is the carry into bit 14, used in the same cycle.
          ovf_d   = c3 ^ c2;
`endif
          state_d = DONE;
        end else begin
          sliceIdx_d = sliceIdx_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADDSUB15_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_addsub15_slice_seq.sv
// Directed self-checking bench for addsub15_slice_seq; expected values are hand-computed
// or come from a plain integer add/sub reference model.
module tb_addsub15_slice_seq;

`ifdef ADDSUB15_OVF_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] a;
  logic [14:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  addsub15_slice_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation in IDLE and returns cycles from accept edge to out_valid (-1 on timeout).
  task automatic applyStimulus(input logic [14:0] av, input logic [14:0] bv, input logic sv,
                               output int lat);
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic refModel(input logic [14:0] av, input logic [14:0] bv, input logic sv,
                          output logic [14:0] s, output logic c, output logic o);
    logic [14:0] bm;
    logic [15:0] full;
    bm   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bm} + {15'd0, sv};
    s    = full[14:0];
    c    = full[15];
    o    = OvfEn & (av[14] == bm[14]) & (s[14] != av[14]);
  endtask

  typedef struct {
    logic [14:0] va;
    logic [14:0] vb;
    logic        vs;
  } vecT;

  initial begin
    int          lat;
    vecT         vecs[5];
    logic [14:0] expS;
    logic        expC;
    logic        expO;
    int          accIdx;
    int          outIdx;
    int          lastAcc;
    logic        accNow;
    logic [14:0] heldSum;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    #2;
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_sum", 16'(sum), 16'h0000);
    checkOutput("rst_cout", 16'(cout), 16'd0);
    checkOutput("rst_ovf", 16'(ovf), 16'd0);
    #10 rst_n = 1'b1;
    tick();

    // 0x1234 + 0x0456
    applyStimulus(15'h1234, 15'h0456, 1'b0, lat);
    checkOutput("add1_latency", 16'(lat), 16'd5);
    checkOutput("add1_sum", 16'(sum), 16'h168A);
    checkOutput("add1_cout", 16'(cout), 16'd0);
    checkOutput("add1_ovf", 16'(ovf), 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("add1_hs_out_valid", 16'(out_valid), 16'd0);
    checkOutput("add1_hs_in_ready", 16'(in_ready), 16'd1);

    // -1 - 1
    applyStimulus(15'h7FFF, 15'h0001, 1'b1, lat);
    checkOutput("sub1_latency", 16'(lat), 16'd5);
    checkOutput("sub1_sum", 16'(sum), 16'h7FFE);
    checkOutput("sub1_cout", 16'(cout), 16'd1);
    checkOutput("sub1_ovf", 16'(ovf), 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Largest positive + 1 overflows into the sign bit
    applyStimulus(15'h3FFF, 15'h0001, 1'b0, lat);
    checkOutput("ovf_sum", 16'(sum), 16'h4000);
    checkOutput("ovf_cout", 16'(cout), 16'd0);
    checkOutput("ovf_ovf", 16'(ovf), 16'(OvfEn));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 0 - 1 with the consumer stalling for 10 cycles
    applyStimulus(15'h0000, 15'h0001, 1'b1, lat);
    checkOutput("borrow_sum", 16'(sum), 16'h7FFF);
    checkOutput("borrow_cout", 16'(cout), 16'd0);
    checkOutput("borrow_ovf", 16'(ovf), 16'd0);
    heldSum = 15'h7FFF;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 15'h0111 * 15'(i + 1);
      b        = 15'h0023;
      sub      = 1'b0;
      tick();
      checkOutput("stall_out_valid", 16'(out_valid), 16'd1);
      checkOutput("stall_sum", 16'(sum), 16'(heldSum));
      checkOutput("stall_in_ready", 16'(in_ready), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_queue_in_ready", 16'(in_ready), 16'd1);
      checkOutput("no_queue_out_valid", 16'(out_valid), 16'd0);
    end

    // Back-to-back with both handshakes held high
    vecs[0] = '{15'h1234, 15'h0456, 1'b0};
    vecs[1] = '{15'h7FFF, 15'h0001, 1'b1};
    vecs[2] = '{15'h3FFF, 15'h0001, 1'b0};
    vecs[3] = '{15'h0100, 15'h0200, 1'b1};
    vecs[4] = '{15'h5555, 15'h2AAB, 1'b0};
    accIdx    = 0;
    outIdx    = 0;
    lastAcc   = -1;
    a         = vecs[0].va;
    b         = vecs[0].vb;
    sub       = vecs[0].vs;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && outIdx < 5; cyc++) begin
      if (out_valid) begin
        refModel(vecs[outIdx].va, vecs[outIdx].vb, vecs[outIdx].vs, expS, expC, expO);
        checkOutput("b2b_sum", 16'(sum), 16'(expS));
        checkOutput("b2b_cout", 16'(cout), 16'(expC));
        checkOutput("b2b_ovf", 16'(ovf), 16'(expO));
        outIdx++;
      end
      accNow = in_ready && in_valid;
      tick();
      if (accNow) begin
        if (accIdx > 0) checkOutput("b2b_spacing", 16'(cyc - lastAcc), 16'd7);
        lastAcc = cyc;
        accIdx++;
        if (accIdx < 5) begin
          a   = vecs[accIdx].va;
          b   = vecs[accIdx].vb;
          sub = vecs[accIdx].vs;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b_results", 16'(outIdx), 16'd5);
    out_ready = 1'b0;
    tick();

    // Reset during the third RUN cycle discards the operation
    a        = 15'h1111;
    b        = 15'h2222;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrun_in_ready", 16'(in_ready), 16'd1);
    checkOutput("midrun_sum", 16'(sum), 16'h0000);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_out_valid", 16'(out_valid), 16'd0);
    applyStimulus(15'h0005, 15'h0003, 1'b0, lat);
    checkOutput("post_rst_latency", 16'(lat), 16'd5);
    checkOutput("post_rst_sum", 16'(sum), 16'h0008);
    checkOutput("post_rst_cout", 16'(cout), 16'd0);
    checkOutput("post_rst_ovf", 16'(ovf), 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
